// File: rtl/psum_acc_writeback.sv
// psum_acc_writeback: pops psum vectors from the OFIFO, accumulates kij
// passes into an on-chip bank with saturation, then writes the ReLU'd
// results to the output SRAM as a self-timed burst.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for pass_start; OFIFO not popped
// ACCUM     | popping num_out vectors and folding them into the bank
// WRITEBACK | one SRAM write per cycle, addresses 0..num_out-1
// DONE      | single-cycle wb_done pulse, then back to IDLE
module psum_acc_writeback #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int num_out = 16,
    parameter int addr_w  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pass_start,
    input  logic                     pass_first,
    input  logic                     pass_last,
    input  logic                     in_valid,
    input  logic [col*psum_bw-1:0]   in_data,
    output logic                     in_ready,
    output logic [col*psum_bw-1:0]   op_d,
    output logic [addr_w-1:0]        op_addr,
    output logic                     op_cen,
    output logic                     op_wen,
    output logic                     pass_done,
    output logic                     wb_done,
    output logic                     busy,
    output logic                     sat_flag
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCUM     = 2'd1,
        WRITEBACK = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [addr_w-1:0] last_idx = addr_w'(num_out - 1);
    localparam logic [psum_bw-1:0] pos_max = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] neg_min = {1'b1, {(psum_bw-1){1'b0}}};

    state_t                     state_q, state_d;
    logic [addr_w-1:0]          idx_q, idx_d;
    logic [addr_w-1:0]          wcnt_q, wcnt_d;
    logic                       first_q, first_d;
    logic                       last_q, last_d;
    logic                       sat_q, sat_d;
    logic                       pass_done_q, pass_done_d;
    logic                       wb_done_q, wb_done_d;
    logic                       wr_cen_q, wr_cen_d;
    logic                       wr_wen_q, wr_wen_d;
    logic [addr_w-1:0]          wr_addr_q, wr_addr_d;
    logic [col*psum_bw-1:0]     wr_data_q, wr_data_d;
    logic [col*psum_bw-1:0]     acc_q [num_out];
    logic [col*psum_bw-1:0]     acc_d [num_out];

    logic                       load_wb;
    logic [addr_w-1:0]          wb_sel;
    logic [col*psum_bw-1:0]     row_new;
    logic [col*psum_bw-1:0]     row_relu;
    logic                       row_sat;

    // Add at psum_bw+1 bits and clamp; MSB of the result flags a clamp.
    function automatic logic [psum_bw:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
        logic [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1]) begin
            return {1'b1, (s[psum_bw] ? neg_min : pos_max)};
        end
        return {1'b0, s[psum_bw-1:0]};
    endfunction

    // Per-lane update of the row addressed by idx for the current transfer.
    always_comb begin
        row_new = '0;
        row_sat = 1'b0;
        for (int i = 0; i < col; i++) begin
            logic [psum_bw:0] r;
            if (first_q) begin
                r = {1'b0, in_data[psum_bw*i +: psum_bw]};
            end else begin
                r = sat_add(acc_q[idx_q][psum_bw*i +: psum_bw],
                            in_data[psum_bw*i +: psum_bw]);
            end
            row_new[psum_bw*i +: psum_bw] = r[psum_bw-1:0];
            row_sat = row_sat | r[psum_bw];
        end
    end

    // Next-state, bank update and writeback launch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        first_d     = first_q;
        last_d      = last_q;
        sat_d       = sat_q;
        acc_d       = acc_q;
        pass_done_d = 1'b0;
        wb_done_d   = 1'b0;
        load_wb     = 1'b0;
        wb_sel      = '0;
        case (state_q)
            IDLE: begin
                if (pass_start) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                    first_d = pass_first;
                    last_d  = pass_last;
                    if (pass_first) begin
                        sat_d = 1'b0;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d[idx_q] = row_new;
                    sat_d        = sat_q | row_sat;
                    if (idx_q == last_idx) begin
                        idx_d = '0;
                        if (last_q) begin
                            state_d = WRITEBACK;
                            wcnt_d  = '0;
                            load_wb = 1'b1;
                            wb_sel  = '0;
                        end else begin
                            state_d     = IDLE;
                            pass_done_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                if (wcnt_q == last_idx) begin
                    state_d   = DONE;
                    wb_done_d = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                    load_wb = 1'b1;
                    wb_sel  = wcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ReLU of the row about to be written; reads the post-update bank so a
    // row touched by the final transfer is already current.
    always_comb begin
        row_relu = '0;
        for (int i = 0; i < col; i++) begin
            if (acc_d[wb_sel][psum_bw*i + psum_bw - 1]) begin
                row_relu[psum_bw*i +: psum_bw] = '0;
            end else begin
                row_relu[psum_bw*i +: psum_bw] = acc_d[wb_sel][psum_bw*i +: psum_bw];
            end
        end
    end

    // SRAM port: strobes only for a launched write, address/data hold otherwise.
    always_comb begin
        wr_cen_d  = 1'b1;
        wr_wen_d  = 1'b1;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (load_wb) begin
            wr_cen_d  = 1'b0;
            wr_wen_d  = 1'b0;
            wr_addr_d = wb_sel;
            wr_data_d = row_relu;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wcnt_q      <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            sat_q       <= 1'b0;
            pass_done_q <= 1'b0;
            wb_done_q   <= 1'b0;
            wr_cen_q    <= 1'b1;
            wr_wen_q    <= 1'b1;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            first_q     <= first_d;
            last_q      <= last_d;
            sat_q       <= sat_d;
            pass_done_q <= pass_done_d;
            wb_done_q   <= wb_done_d;
            wr_cen_q    <= wr_cen_d;
            wr_wen_q    <= wr_wen_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Accumulator bank; reset discards any partial tile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < num_out; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < num_out; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign op_d      = wr_data_q;
    assign op_addr   = wr_addr_q;
    assign op_cen    = wr_cen_q;
    assign op_wen    = wr_wen_q;
    assign pass_done = pass_done_q;
    assign wb_done   = wb_done_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_psum_acc_writeback.sv
// Directed bench for psum_acc_writeback with a write scoreboard.
module tb_psum_acc_writeback;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int NO  = 16;
    localparam int AW  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pass_start = 1'b0;
    logic              pass_first = 1'b0;
    logic              pass_last = 1'b0;
    logic              in_valid = 1'b0;
    logic [COL*BW-1:0] in_data = '0;
    logic              in_ready;
    logic [COL*BW-1:0] op_d;
    logic [AW-1:0]     op_addr;
    logic              op_cen;
    logic              op_wen;
    logic              pass_done;
    logic              wb_done;
    logic              busy;
    logic              sat_flag;

    psum_acc_writeback dut (
        .clk(clk), .reset(reset), .pass_start(pass_start),
        .pass_first(pass_first), .pass_last(pass_last),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .op_d(op_d), .op_addr(op_addr), .op_cen(op_cen), .op_wen(op_wen),
        .pass_done(pass_done), .wb_done(wb_done), .busy(busy),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]     addr;
        logic [COL*BW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  macc [NO][COL];
    bit  msat = 1'b0;

    task automatic chk(input string tag, input logic [COL*BW-1:0] obs,
                       input logic [COL*BW-1:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic int lane_val(input int mode, input int j, input int i);
        case (mode)
            0: return j + i;
            1: return 1;
            2: return 28672;
            3: return -2;
            4: return j * 8 + i - 40;
            5: return 5;
            default: return 3;
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NO; k++)
            for (int i = 0; i < COL; i++) macc[k][i] = 0;
        msat = 1'b0;
    endtask

    // Every SRAM write strobe is matched against the scoreboard head.
    always @(negedge clk) begin
        if (op_cen === 1'b0) begin
            wr_t e;
            n_chk++;
            assert (exp_q.size() != 0) n_pass++;
            else $error("FAIL unexpected_write: observed addr %h expected no write", op_addr);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_wen", {127'd0, op_wen}, '0);
                chk("wr_addr", {124'd0, op_addr}, {124'd0, e.addr});
                chk("wr_data", op_d, e.data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {127'd0, in_ready}, '0);
        chk({tag, "_op_cen"},   {127'd0, op_cen},   128'd1);
        chk({tag, "_op_wen"},   {127'd0, op_wen},   128'd1);
        chk({tag, "_busy"},     {127'd0, busy},     '0);
        chk({tag, "_sat"},      {127'd0, sat_flag}, '0);
        chk({tag, "_op_addr"},  {124'd0, op_addr},  '0);
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_pass(input bit first, input bit last, input int mode,
                            input bit gap, input int abort_at, input bit repulse,
                            input int wb_abort);
        int cnt;
        pass_start = 1'b1;
        pass_first = first;
        pass_last  = last;
        if (first) msat = 1'b0;
        @(negedge clk);
        pass_start = 1'b0;
        for (int j = 0; j < NO; j++) begin
            if (j == abort_at) begin
                in_valid = 1'b0;
                reset = 1'b1;
                #1;
                check_reset_outputs("rst_accum");
                model_clear();
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (gap) begin
                while ($urandom_range(0, 2) != 0) begin
                    in_valid = 1'b0;
                    in_data  = '1;
                    @(negedge clk);
                    chk("in_ready_gap", {127'd0, in_ready}, 128'd1);
                end
            end
            in_valid = 1'b1;
            for (int i = 0; i < COL; i++) begin
                int v, s;
                v = lane_val(mode, j, i);
                in_data[BW*i +: BW] = BW'(v);
                s = first ? v : macc[j][i] + v;
                if (s > 32767) begin s = 32767; msat = 1'b1; end
                if (s < -32768) begin s = -32768; msat = 1'b1; end
                macc[j][i] = s;
            end
            if (repulse && j == 5) begin
                pass_start = 1'b1;
                pass_first = 1'b1;
                pass_last  = 1'b0;
            end
            if (last && j == NO - 1) begin
                for (int k = 0; k < NO; k++) begin
                    wr_t e;
                    e.addr = AW'(k);
                    for (int i = 0; i < COL; i++)
                        e.data[BW*i +: BW] = (macc[k][i] < 0) ? '0 : BW'(macc[k][i]);
                    exp_q.push_back(e);
                end
            end
            chk("in_ready", {127'd0, in_ready}, 128'd1);
            @(negedge clk);
            pass_start = 1'b0;
            pass_last  = last;
        end
        in_valid = 1'b0;
        if (!last) begin
            chk("pass_done", {127'd0, pass_done}, 128'd1);
            chk("busy_after_pass", {127'd0, busy}, '0);
            return;
        end
        cnt = 1;
        while (wb_done !== 1'b1 && cnt < 40) begin
            if (cnt == wb_abort) begin
                #2 reset = 1'b1;
                #1;
                check_reset_outputs("rst_wb");
                exp_q.delete();
                model_clear();
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (repulse && cnt == 5) begin
                pass_start = 1'b1;
                pass_first = 1'b1;
                pass_last  = 1'b0;
            end
            @(negedge clk);
            pass_start = 1'b0;
            cnt++;
        end
        chk("wb_latency", 128'(cnt), 128'd17);
        chk("wb_queue_empty", 128'(exp_q.size()), '0);
        chk("done_op_cen", {127'd0, op_cen}, 128'd1);
        chk("done_busy", {127'd0, busy}, 128'd1);
        @(negedge clk);
        chk("wb_done_pulse", {127'd0, wb_done}, '0);
        chk("idle_busy", {127'd0, busy}, '0);
        chk("sat_flag", {127'd0, sat_flag}, {127'd0, msat});
    endtask

    task automatic run_tile(input int mode, input bit gap);
        for (int p = 0; p < 9; p++)
            run_pass(p == 0, p == 8, mode, gap, -1, 1'b0, -1);
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_op_d", op_d, '0);
        chk("reset_pass_done", {127'd0, pass_done}, '0);
        reset = 1'b0;
        @(negedge clk);

        run_pass(1'b1, 1'b1, 0, 1'b0, -1, 1'b0, -1);
        run_tile(1, 1'b0);
        run_tile(2, 1'b0);
        chk("sat_set", {127'd0, sat_flag}, 128'd1);
        run_tile(3, 1'b0);
        run_pass(1'b1, 1'b1, 0, 1'b1, -1, 1'b0, -1);
        run_pass(1'b1, 1'b0, 4, 1'b1, -1, 1'b0, -1);
        run_pass(1'b0, 1'b1, 4, 1'b0, -1, 1'b1, -1);

        for (int p = 0; p < 4; p++)
            run_pass(p == 0, 1'b0, 1, 1'b0, (p == 3) ? 7 : -1, 1'b0, -1);
        run_pass(1'b1, 1'b1, 5, 1'b0, -1, 1'b0, -1);

        run_pass(1'b1, 1'b1, 5, 1'b0, -1, 1'b0, 5);
        run_pass(1'b0, 1'b1, 6, 1'b0, -1, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/psum_acc_writeback.md
Name: psum_acc_writeback

Overview:
- Sits directly downstream of the corelet OFIFO.
- Pops one 8-lane psum vector per output pixel for each kernel pass (kij), and accumulates 9 kij passes into a 16-entry on-chip accumulator bank.
- After the last pass, applies ReLU and writes the 16 results into the output SRAM (128-bit words, addresses 0–15).
- Replaces the hard-coded SFU-to-OUTSRAM sequencing with a handshaked, self-timed stage.

Parameters:
- col, 8, lanes per vector
- psum_bw, 16, signed width per lane
- num_out, 16, output pixels (vectors) per pass
- addr_w, 4, output SRAM address width (num_out <= 2^addr_w)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- pass_start  input  1  one-cycle pulse; begins a kij pass
- pass_first  input  1  sampled with pass_start; this pass overwrites instead of accumulating
- pass_last  input  1  sampled with pass_start; writeback follows this pass
- in_valid  input  1  OFIFO has a vector available
- in_data  input  col*psum_bw  lane i = in_data[psum_bw*i +: psum_bw], signed
- in_ready  output  1  pop strobe to OFIFO; a transfer occurs when in_valid && in_ready
- op_d  output  col*psum_bw  write data to output SRAM
- op_addr  output  addr_w  output SRAM address
- op_cen  output  1  output SRAM chip enable, active-low
- op_wen  output  1  output SRAM write enable, active-low
- pass_done  output  1  one-cycle pulse after the num_out-th transfer of a non-last pass
- wb_done  output  1  one-cycle pulse after the final SRAM write
- busy  output  1  high in any state other than IDLE
- sat_flag  output  1  sticky; set on any lane saturation; cleared by reset or by a pass_start with pass_first=1

Behaviour:
- Reset values: in_ready=0, op_cen=1, op_wen=1, op_addr=0, op_d=0, pass_done=0, wb_done=0, busy=0, sat_flag=0, state=IDLE, idx=0. Accumulator contents become 0.
- States: IDLE, ACCUM, WRITEBACK, DONE.
- IDLE:
  - pass_start=1 → ACCUM next cycle, idx=0.
  - first_q and last_q latch pass_first and pass_last on that edge.
  - in_valid is ignored (in_ready=0).
- ACCUM:
  - in_ready=1 combinationally while state==ACCUM.
  - Each transfer updates, for every lane i: acc[idx][i] = sat(first_q ? in_i : acc[idx][i] + in_i), then idx increments.
  - Gaps in in_valid stall idx without losing state.
  - On the transfer with idx==num_out-1:
    - last_q=0 → IDLE, with pass_done=1 for the next cycle.
    - last_q=1 → WRITEBACK, with wcnt=0.
- Arithmetic:
  - Sum is computed at psum_bw+1 bits, then clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1] (0x8000..0x7FFF for 16-bit).
  - Any clamp sets sat_flag.
- WRITEBACK: exactly num_out consecutive cycles, k = 0..num_out-1.
  - op_cen=0, op_wen=0, op_addr=k, op_d lane i = (acc[k][i] < 0) ? 0 : acc[k][i].
  - These outputs are registered and valid during cycle k.
  - in_ready=0.
  - After k=num_out-1 → DONE.
- DONE:
  - One cycle: wb_done=1, op_cen=1, op_wen=1, busy=1.
  - Then IDLE.
  - The accumulator is retained; it is only overwritten by a later pass_first pass.
- Outside WRITEBACK: op_cen=1 and op_wen=1; op_addr and op_d hold their last values.
- pass_start outside IDLE is ignored, with no state change.
- pass_start in the same cycle pass_done is high (state is IDLE) is accepted.
- A pass without pass_first after wb_done continues accumulating onto the retained values. Legal, not used by the controller.
- Reset asserted mid-ACCUM or mid-WRITEBACK:
  - Outputs return to their reset values immediately (asynchronously).
  - No further SRAM write strobes are issued.
  - The partial tile is discarded.
- Latency: the first SRAM write occurs the cycle after the final transfer of the last pass. wb_done occurs num_out+1 cycles after that transfer.

Test Plan:
- Single pass, first=last=1, vector j lanes = j+i → addrs 0..15 written in 16 consecutive cycles, op_d[j] lane i = j+i, then wb_done one cycle later; sat_flag=0.
- 9 passes, all lanes +1, first only on pass 0, last on pass 8 → every lane written = 9; pass_done pulses 8 times; wb_done once.
- 9 passes of 0x7000 → every lane written 0x7FFF, sat_flag=1; 9 passes of 0xFFFE → lanes written 0 (ReLU), sat_flag unaffected.
- in_valid toggling 1-0-0-1 randomly during a pass → exactly 16 transfers are counted and results match the gap-free run; in_ready stays high through the gaps.
- pass_start re-pulsed mid-ACCUM and mid-WRITEBACK → ignored; addresses and data unchanged.
- Reset asserted at transfer 7 of pass 3 → op_cen=1, busy=0 immediately; a new first=last pass of 5s then writes 5 to every lane.
